// File: rtl/counter_sweep_ctrl_if.sv
// Host-side handshake and configuration bundle for counter_sweep_ctrl.
// The host drives start/abort/config as master; the controller reports status as slave.
interface counter_sweep_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic             abort;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] hi;
  logic [3:0]       sweeps;
  logic             busy;
  logic             done;
  logic             cfg_err;
  logic             track_err;
  logic [3:0]       sweep_cnt;

  modport master (
    output start, abort, lo, hi, sweeps,
    input  busy, done, cfg_err, track_err, sweep_cnt
  );

  modport slave (
    input  start, abort, lo, hi, sweeps,
    output busy, done, cfg_err, track_err, sweep_cnt
  );
endinterface

// File: rtl/counter_sweep_ctrl.sv
// Sequences an external up/down counter through lo->hi->lo triangle sweeps,
// pacing one step pulse every DIV cycles and checking the counter against a shadow count.
module counter_sweep_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  counter_sweep_ctrl_if.slave host,
  input  logic [WIDTH-1:0] counter_out_i,
  output logic             cnt_rst_o,
  output logic             cnt_enable_o,
  output logic             cnt_direction_o
);

  localparam int unsigned PW = (DIV > 2) ? $clog2(DIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SEEK,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t           state_q;
  logic             cnt_rst_q, cnt_enable_q, cnt_dir_q;
  logic             busy_q, done_q, cfg_err_q, track_err_q;
  logic [3:0]       sweep_cnt_q, sweeps_q;
  logic [WIDTH-1:0] lo_q, hi_q, exp_q, exp_d;
  logic [PW-1:0]    presc_q, presc_d;
  logic             fire, stepping;

  // Shadow count follows exactly the rules the counter applies to our registered controls.
  always_comb begin
    exp_d = exp_q;
    if (cnt_rst_q) begin
      exp_d = '0;
    end else if (cnt_enable_q) begin
      exp_d = cnt_dir_q ? exp_q + 1'b1 : exp_q - 1'b1;
    end
    fire     = (presc_q == PW'(DIV - 1));
    presc_d  = fire ? '0 : presc_q + 1'b1;
    stepping = (state_q == S_SEEK) || (state_q == S_UP) || (state_q == S_DOWN);
  end

  // Turnarounds are decided on the pulse edge using exp_d, so the direction
  // register changes going into a pulse-free cycle and the pulse grid is kept intact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_rst_q    <= 1'b1;
      cnt_enable_q <= 1'b0;
      cnt_dir_q    <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      track_err_q  <= 1'b0;
      sweep_cnt_q  <= '0;
      sweeps_q     <= '0;
      lo_q         <= '0;
      hi_q         <= '0;
      exp_q        <= '0;
      presc_q      <= '0;
    end else begin
      exp_q        <= exp_d;
      presc_q      <= presc_d;
      cnt_enable_q <= 1'b0;
      done_q       <= 1'b0;
      cfg_err_q    <= 1'b0;
      if (stepping && (counter_out_i != exp_q)) begin
        track_err_q <= 1'b1;
      end
      if (busy_q && host.abort) begin
        state_q   <= S_IDLE;
        busy_q    <= 1'b0;
        cnt_rst_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_rst_q <= 1'b0;
            if (host.start) begin
              if ((host.lo < host.hi) && (host.sweeps != 4'd0)) begin
                lo_q        <= host.lo;
                hi_q        <= host.hi;
                sweeps_q    <= host.sweeps;
                track_err_q <= 1'b0;
                sweep_cnt_q <= '0;
                busy_q      <= 1'b1;
                cnt_rst_q   <= 1'b1;
                cnt_dir_q   <= 1'b1;
                state_q     <= S_CLEAR;
              end else begin
                cfg_err_q <= 1'b1;
              end
            end
          end
          S_CLEAR: begin
            cnt_rst_q    <= 1'b0;
            cnt_enable_q <= 1'b1;
            presc_q      <= '0;
            state_q      <= (lo_q == '0) ? S_UP : S_SEEK;
          end
          S_SEEK: begin
            if (cnt_enable_q && (exp_d == lo_q)) begin
              state_q <= S_UP;
            end else if (fire) begin
              cnt_enable_q <= 1'b1;
            end
          end
          S_UP: begin
            if (cnt_enable_q && (exp_d == hi_q)) begin
              state_q   <= S_DOWN;
              cnt_dir_q <= 1'b0;
            end else if (fire) begin
              cnt_enable_q <= 1'b1;
            end
          end
          S_DOWN: begin
            if (cnt_enable_q && (exp_d == lo_q)) begin
              sweep_cnt_q <= sweep_cnt_q + 4'd1;
              if (4'(sweep_cnt_q + 4'd1) == sweeps_q) begin
                state_q <= S_DONE;
              end else begin
                state_q   <= S_UP;
                cnt_dir_q <= 1'b1;
              end
            end else if (fire) begin
              cnt_enable_q <= 1'b1;
            end
          end
          S_DONE: begin
            if (done_q) begin
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end else if (fire) begin
              done_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign cnt_rst_o       = cnt_rst_q;
  assign cnt_enable_o    = cnt_enable_q;
  assign cnt_direction_o = cnt_dir_q;
  assign host.busy       = busy_q;
  assign host.done       = done_q;
  assign host.cfg_err    = cfg_err_q;
  assign host.track_err  = track_err_q;
  assign host.sweep_cnt  = sweep_cnt_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// Bench for counter_sweep_ctrl: an 8-bit up/down counter model closes the loop and
// each run is checked cycle by cycle against a step sequence derived from lo/hi/sweeps.
module tb_counter_sweep_ctrl;
  localparam int unsigned DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] counter;
  logic       cnt_rst, cnt_enable, cnt_direction;
  int unsigned skip_req = 0;
  int unsigned skip_taken = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;

  counter_sweep_ctrl_if #(.WIDTH(8)) bus ();

  counter_sweep_ctrl #(.WIDTH(8), .DIV(DIV)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host           (bus),
    .counter_out_i  (counter),
    .cnt_rst_o      (cnt_rst),
    .cnt_enable_o   (cnt_enable),
    .cnt_direction_o(cnt_direction)
  );

  always #5 clk = ~clk;

  // Counter under control; can be told to swallow one upward step.
  always_ff @(posedge clk) begin
    if (cnt_rst) begin
      counter <= '0;
    end else if (cnt_enable) begin
      if (cnt_direction && (skip_req != skip_taken)) begin
        skip_taken <= skip_taken + 1;
      end else begin
        counter <= cnt_direction ? counter + 8'd1 : counter - 8'd1;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_rst"},   32'(cnt_rst), 32'd1);
    check_eq({tag, "_en"},    32'(cnt_enable), 32'd0);
    check_eq({tag, "_dir"},   32'(cnt_direction), 32'd1);
    check_eq({tag, "_busy"},  32'(bus.busy), 32'd0);
    check_eq({tag, "_done"},  32'(bus.done), 32'd0);
    check_eq({tag, "_cfg"},   32'(bus.cfg_err), 32'd0);
    check_eq({tag, "_trk"},   32'(bus.track_err), 32'd0);
    check_eq({tag, "_swcnt"}, 32'(bus.sweep_cnt), 32'd0);
  endtask

  // One full run; the expected trace is built from the triangle sequence and the DIV spacing.
  task automatic do_run(input logic [7:0] l, input logic [7:0] h, input logic [3:0] s,
                        input logic with_abort);
    logic [7:0]  seq[$];
    logic [7:0]  v;
    int unsigned n, last, k;
    seq.push_back(8'd0);
    v = 8'd0;
    while (v < l) begin v++; seq.push_back(v); end
    for (int unsigned w = 0; w < 32'(s); w++) begin
      while (v < h) begin v++; seq.push_back(v); end
      while (v > l) begin v--; seq.push_back(v); end
    end
    n    = 32'(seq.size()) - 1;
    last = 2 + n * DIV;
    @(negedge clk);
    bus.start = 1'b1; bus.abort = with_abort; bus.lo = l; bus.hi = h; bus.sweeps = s;
    for (int unsigned t = 0; t <= last; t++) begin
      @(negedge clk);
      bus.start = 1'b0; bus.abort = 1'b0;
      k = (t < 2) ? 0 : (t - 2) / DIV + 1;
      if (k > n) k = n;
      check_eq("run_busy", 32'(bus.busy), 32'(t <= 1 + n * DIV));
      check_eq("run_done", 32'(bus.done), 32'(t == 1 + n * DIV));
      check_eq("run_rst",  32'(cnt_rst), 32'(t == 0));
      check_eq("run_en",   32'(cnt_enable),
               32'((t >= 1) && ((t - 1) % DIV == 0) && ((t - 1) / DIV < n)));
      check_eq("run_trk",  32'(bus.track_err), 32'd0);
      if (t >= 1) check_eq("run_cnt", 32'(counter), 32'(seq[k]));
      if (t >= 1 + n * DIV) check_eq("run_swcnt", 32'(bus.sweep_cnt), 32'(s));
    end
  endtask

  task automatic bad_cfg(input logic [7:0] l, input logic [7:0] h, input logic [3:0] s);
    @(negedge clk);
    bus.start = 1'b1; bus.lo = l; bus.hi = h; bus.sweeps = s;
    @(negedge clk);
    bus.start = 1'b0;
    check_eq("bad_cfg_pulse", 32'(bus.cfg_err), 32'd1);
    check_eq("bad_busy", 32'(bus.busy), 32'd0);
    check_eq("bad_rst",  32'(cnt_rst), 32'd0);
    check_eq("bad_en",   32'(cnt_enable), 32'd0);
    @(negedge clk);
    check_eq("bad_cfg_clear", 32'(bus.cfg_err), 32'd0);
    check_eq("bad_busy2", 32'(bus.busy), 32'd0);
    check_eq("bad_en2",   32'(cnt_enable), 32'd0);
  endtask

  initial begin
    logic       found;
    logic       got_done;
    logic [7:0] rl, rh;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.abort = 1'b0; bus.lo = '0; bus.hi = '0; bus.sweeps = '0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    check_eq("reset_cnt", 32'(counter), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle_rst", 32'(cnt_rst), 32'd0);

    // abort in IDLE is ignored
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("idle_abort_busy", 32'(bus.busy), 32'd0);

    do_run(8'd2, 8'd5, 4'd1, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("nominal_hold", 32'(counter), 32'd2);
    do_run(8'd0, 8'd3, 4'd2, 1'b0);
    do_run(8'd1, 8'd2, 4'd1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      rl = 8'($urandom_range(0, 8));
      rh = rl + 8'($urandom_range(1, 6));
      do_run(rl, rh, 4'($urandom_range(1, 3)), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    bad_cfg(8'd5, 8'd5, 4'd1);
    bad_cfg(8'd1, 8'd4, 4'd0);
    bad_cfg(8'd7, 8'd3, 4'd2);

    // abort while counting up through 4
    @(negedge clk);
    bus.start = 1'b1; bus.lo = 8'd2; bus.hi = 8'd7; bus.sweeps = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (counter == 8'd4) found = 1'b1;
    end
    check_eq("abort_reach4", 32'(found), 32'd1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_eq("abort_busy", 32'(bus.busy), 32'd0);
    check_eq("abort_en",   32'(cnt_enable), 32'd0);
    for (int i = 0; i < 3 * DIV; i++) begin
      @(negedge clk);
      check_eq("abort_nodone", 32'(bus.done), 32'd0);
      check_eq("abort_hold",   32'(counter), 32'd4);
    end
    do_run(8'd1, 8'd3, 4'd1, 1'b0);

    // swallowed increment must raise track_err one cycle later; run still completes
    skip_req = skip_req + 1;
    @(negedge clk);
    bus.start = 1'b1; bus.lo = 8'd1; bus.hi = 8'd3; bus.sweeps = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_eq("trk_before", 32'(bus.track_err), 32'd0);
    @(negedge clk);
    check_eq("trk_set", 32'(bus.track_err), 32'd1);
    got_done = 1'b0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      @(negedge clk);
      if (bus.done) got_done = 1'b1;
    end
    check_eq("trk_done", 32'(got_done), 32'd1);
    check_eq("trk_sticky", 32'(bus.track_err), 32'd1);
    @(negedge clk);
    check_eq("trk_busy_low", 32'(bus.busy), 32'd0);
    do_run(8'd2, 8'd4, 4'd1, 1'b0);

    // reset pulse during the downward leg
    @(negedge clk);
    bus.start = 1'b1; bus.lo = 8'd1; bus.hi = 8'd4; bus.sweeps = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (!cnt_direction && bus.busy) found = 1'b1;
    end
    check_eq("rstmid_down", 32'(found), 32'd1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("rstmid");
    @(negedge clk);
    check_reset_vals("rstmid_hold");
    check_eq("rstmid_cnt", 32'(counter), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rstmid_idle_busy", 32'(bus.busy), 32'd0);
    check_eq("rstmid_idle_rst",  32'(cnt_rst), 32'd0);
    check_eq("rstmid_idle_en",   32'(cnt_enable), 32'd0);
    @(negedge clk);
    check_eq("rstmid_cnt_hold", 32'(counter), 32'd0);
    do_run(8'd3, 8'd6, 4'd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
